// File: rtl/ir_key_pkg.sv
// Shared definitions for the IR key event queue: register map, bit positions,
// FSM encoding and the queued entry layout.
package ir_key_pkg;

  localparam logic [2:0] REG_HEAD   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_FILT   = 3'd3;
  localparam logic [2:0] REG_CLR    = 3'd4;
  localparam logic [2:0] REG_FLUSH  = 3'd5;

  localparam int unsigned ST_FULL = 7;
  localparam int unsigned ST_OVF  = 8;
  localparam int unsigned ST_CHK  = 9;
  localparam int unsigned ST_REP  = 10;
  localparam int unsigned ST_IE   = 11;

  localparam int unsigned CTRL_IE   = 0;
  localparam int unsigned CTRL_FILT = 1;
  localparam int unsigned CTRL_REP  = 2;

  typedef enum logic {
    StIdle  = 1'b0,
    StCheck = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] addr8;
    logic [7:0] cmd8;
  } entry_t;

  // High byte of a frame must be the bitwise inverse of the command byte.
  function automatic logic cmd_ok(input logic [15:0] data);
    return data[15:8] == ~data[7:0];
  endfunction

endpackage

// File: rtl/ir_key_fifo.sv
// Synchronous FIFO with flush; count is a separate register so a full queue
// is distinguishable from an empty one with wrapped pointers.
module ir_key_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_rdata,
  output logic [6:0]       o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [6:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count = r_count;
  assign o_full  = (r_count == 7'(DEPTH));
  assign o_empty = (r_count == 7'd0);
  assign o_rdata = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot a full-queue push needs.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 7'd0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 7'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 7'd1;
        2'b01:   r_count <= r_count - 7'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/ir_key_queue_ctrl.sv
// Validates decoded IR frames (complement, address filter, repeat holdoff) and
// queues accepted key events for the CPU behind a small register map.
module ir_key_queue_ctrl
  import ir_key_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned HOLDOFF_CYCLES = 5500000,
  parameter int unsigned HOLD_W         = 23
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_reset_n,
  input  logic        i_cpu_cs,
  input  logic        i_cpu_read,
  input  logic        i_cpu_write,
  input  logic [2:0]  i_cpu_addr,
  input  logic [15:0] i_cpu_wrdata,
  output logic [15:0] o_cpu_rddata,
  output logic        o_cpu_irq,
  input  logic        i_dec_valid,
  input  logic [15:0] i_dec_data,
  input  logic [15:0] i_dec_addr
);

  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLDOFF_CYCLES);

  state_e            r_state;
  logic [15:0]       r_data;
  logic [15:0]       r_addr;
  logic [2:0]        r_ctrl;
  logic [15:0]       r_filter;
  logic [HOLD_W-1:0] r_hold;
  entry_t            r_last;
  logic              r_ovf;
  logic              r_chk;
  logic              r_rep;
  logic [15:0]       r_rddata;
  logic              r_irq;

  logic        w_rd;
  logic        w_wr;
  logic        w_pop;
  logic        w_pop_eff;
  logic        w_flush;
  logic        w_clr;
  entry_t      w_entry;
  logic        w_filt_miss;
  logic        w_rep_hit;
  logic        w_push;
  logic        w_reload;
  logic        w_set_chk;
  logic        w_set_rep;
  logic        w_set_ovf;
  logic [15:0] w_fifo_rdata;
  logic [6:0]  w_count;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [15:0] w_status;

  assign w_rd      = i_cpu_cs && i_cpu_read;
  assign w_wr      = i_cpu_cs && i_cpu_write;
  assign w_pop     = w_rd && (i_cpu_addr == REG_HEAD);
  assign w_pop_eff = w_pop && !w_fifo_empty;
  assign w_flush   = w_wr && (i_cpu_addr == REG_FLUSH);
  assign w_clr     = w_wr && (i_cpu_addr == REG_CLR);

  assign w_entry     = '{addr8: r_addr[7:0], cmd8: r_data[7:0]};
  assign w_filt_miss = r_ctrl[CTRL_FILT] && (r_addr != r_filter);
  assign w_rep_hit   = r_ctrl[CTRL_REP] && (r_hold != '0) && (w_entry == r_last);

  assign w_status = {4'd0, r_ctrl[CTRL_IE], r_rep, r_chk, r_ovf, w_fifo_full, w_count};

  always_comb begin
    w_push    = 1'b0;
    w_reload  = 1'b0;
    w_set_chk = 1'b0;
    w_set_rep = 1'b0;
    w_set_ovf = 1'b0;
    if (r_state == StCheck) begin
      if (!cmd_ok(r_data)) begin
        w_set_chk = 1'b1;
      end else if (!w_filt_miss) begin
        if (w_rep_hit) begin
          w_set_rep = 1'b1;
          w_reload  = 1'b1;
        end else if (w_fifo_full && !w_pop_eff) begin
          w_set_ovf = 1'b1;
        end else begin
          w_push   = 1'b1;
          w_reload = 1'b1;
        end
      end
      // The FSM cannot latch a new frame while it is still judging one.
      if (i_dec_valid) w_set_ovf = 1'b1;
    end
  end

  ir_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .i_clk   (i_cpu_clk),
    .i_rst_n (i_cpu_reset_n),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_rdata (w_fifo_rdata),
    .o_count (w_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_cpu_clk or negedge i_cpu_reset_n) begin
    if (!i_cpu_reset_n) begin
      r_state  <= StIdle;
      r_data   <= '0;
      r_addr   <= '0;
      r_ctrl   <= '0;
      r_filter <= '0;
      r_hold   <= '0;
      r_last   <= '0;
      r_ovf    <= 1'b0;
      r_chk    <= 1'b0;
      r_rep    <= 1'b0;
      r_rddata <= '0;
      r_irq    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_dec_valid) begin
            r_data  <= i_dec_data;
            r_addr  <= i_dec_addr;
            r_state <= StCheck;
          end
        end
        StCheck: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase

      if (w_reload) begin
        r_hold <= HOLD_RELOAD;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - 1'b1;
      end
      if (w_push) r_last <= w_entry;

      // Clear first so a same-cycle set event takes precedence.
      if (w_clr) begin
        if (i_cpu_wrdata[ST_OVF]) r_ovf <= 1'b0;
        if (i_cpu_wrdata[ST_CHK]) r_chk <= 1'b0;
        if (i_cpu_wrdata[ST_REP]) r_rep <= 1'b0;
      end
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_chk) r_chk <= 1'b1;
      if (w_set_rep) r_rep <= 1'b1;

      if (w_wr && (i_cpu_addr == REG_CTRL)) r_ctrl   <= i_cpu_wrdata[2:0];
      if (w_wr && (i_cpu_addr == REG_FILT)) r_filter <= i_cpu_wrdata;

      if (w_rd) begin
        case (i_cpu_addr)
          REG_HEAD:   r_rddata <= w_fifo_empty ? 16'h0000 : w_fifo_rdata;
          REG_STATUS: r_rddata <= w_status;
          REG_CTRL:   r_rddata <= {13'd0, r_ctrl};
          REG_FILT:   r_rddata <= r_filter;
          default:    r_rddata <= 16'h0000;
        endcase
      end

      r_irq <= r_ctrl[CTRL_IE] && (w_count != 7'd0);
    end
  end

  assign o_cpu_rddata = r_rddata;
  assign o_cpu_irq    = r_irq;

endmodule

// File: tb/tb_ir_key_queue_ctrl.sv
// Self-checking bench for ir_key_queue_ctrl: vector table for frame validation
// plus directed sequences for holdoff, overflow, flush and reset corners.
module tb_ir_key_queue_ctrl;
  import ir_key_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [15:0] wrdata = 16'h0;
  logic [15:0] rddata;
  logic        irq;
  logic        dv = 1'b0;
  logic [15:0] dd = 16'h0;
  logic [15:0] da = 16'h0;

  int total = 0;
  int bad = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [15:0] ctrl;
    logic [15:0] filt;
    logic [15:0] faddr;
    logic [15:0] fdata;
    logic        acc;
    logic [15:0] status;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  ir_key_queue_ctrl #(
    .FIFO_DEPTH     (8),
    .HOLDOFF_CYCLES (100),
    .HOLD_W         (23)
  ) dut (
    .i_cpu_clk     (clk),
    .i_cpu_reset_n (rst_n),
    .i_cpu_cs      (cs),
    .i_cpu_read    (rd),
    .i_cpu_write   (wr),
    .i_cpu_addr    (addr),
    .i_cpu_wrdata  (wrdata),
    .o_cpu_rddata  (rddata),
    .o_cpu_irq     (irq),
    .i_dec_valid   (dv),
    .i_dec_data    (dd),
    .i_dec_addr    (da)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wrdata = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [15:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    d = rddata;
    cs = 1'b0; rd = 1'b0;
  endtask

  // Drives the strobe for one cycle and lets the CHECK cycle complete.
  task automatic frame(input logic [15:0] a, input logic [15:0] d);
    dv = 1'b1; da = a; dd = d;
    tick();
    dv = 1'b0;
    tick();
  endtask

  task automatic sb_push(input logic [15:0] a, input logic [15:0] d);
    sb.push_back({a[7:0], d[7:0]});
  endtask

  task automatic pop_check(input string name);
    logic [15:0] got;
    logic [15:0] exp;
    reg_rd(REG_HEAD, got);
    exp = 16'h0000;
    if (sb.size() != 0) exp = sb.pop_front();
    check(name, got, exp);
  endtask

  task automatic status_check(input string name, input logic [15:0] exp);
    logic [15:0] got;
    reg_rd(REG_STATUS, got);
    check(name, got, exp);
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] e;
    logic [7:0]  cmd;

    vt[0] = '{16'h0000, 16'h0000, 16'h0012, 16'hE719, 1'b0, 16'h0200};
    vt[1] = '{16'h0002, 16'h00FF, 16'h10EF, 16'hE718, 1'b0, 16'h0000};
    vt[2] = '{16'h0002, 16'h00FF, 16'h00FF, 16'hE718, 1'b1, 16'h0001};
    vt[3] = '{16'h0000, 16'h0000, 16'h1234, 16'h55AA, 1'b1, 16'h0002};
    vt[4] = '{16'h0000, 16'h0000, 16'hABCD, 16'h00FF, 1'b1, 16'h0003};
    vt[5] = '{16'h0004, 16'h0000, 16'hABCD, 16'h00FF, 1'b0, 16'h0403};
    vt[6] = '{16'h0004, 16'h0000, 16'hABCD, 16'h01FE, 1'b1, 16'h0004};
    vt[7] = '{16'h0002, 16'h00FF, 16'h1111, 16'h0000, 1'b0, 16'h0204};

    // Reset state
    tick();
    check("reset_rddata", rddata, 16'h0000);
    check("reset_irq", {15'd0, irq}, 16'h0000);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    status_check("reset_status", 16'h0000);
    reg_rd(REG_CTRL, d);
    check("reset_ctrl", d, 16'h0000);
    reg_rd(REG_FILT, d);
    check("reset_filter", d, 16'h0000);
    pop_check("reset_head_empty");

    // Register readback
    reg_wr(REG_FILT, 16'hBEEF);
    reg_rd(REG_FILT, d);
    check("filter_rw", d, 16'hBEEF);
    reg_wr(REG_CTRL, 16'hFFFE);
    reg_rd(REG_CTRL, d);
    check("ctrl_rw", d, 16'h0006);
    reg_rd(3'd6, d);
    check("reg6_zero", d, 16'h0000);

    // Basic frame with interrupt timing
    reg_wr(REG_FILT, 16'h0000);
    reg_wr(REG_CTRL, 16'h0001);
    frame(16'h00FF, 16'hE718);
    sb_push(16'h00FF, 16'hE718);
    check("irq_t2_low", {15'd0, irq}, 16'h0000);
    tick();
    check("irq_t3_high", {15'd0, irq}, 16'h0001);
    status_check("basic_status", 16'h0801);
    pop_check("basic_head");
    check("irq_after_read", {15'd0, irq}, 16'h0001);
    tick();
    check("irq_drop", {15'd0, irq}, 16'h0000);
    reg_wr(REG_CTRL, 16'h0000);

    // Table-driven validation vectors
    for (int i = 0; i < 8; i++) begin
      reg_wr(REG_CTRL, vt[i].ctrl);
      reg_wr(REG_FILT, vt[i].filt);
      frame(vt[i].faddr, vt[i].fdata);
      if (vt[i].acc) sb_push(vt[i].faddr, vt[i].fdata);
      status_check($sformatf("vec%0d_status", i), vt[i].status);
      reg_wr(REG_CLR, 16'h0700);
    end
    reg_wr(REG_CTRL, 16'h0000);
    for (int i = 0; i < 5; i++) pop_check($sformatf("vec_drain%0d", i));

    // Repeat holdoff
    reg_wr(REG_CTRL, 16'h0004);
    frame(16'h0042, 16'h7788);
    sb_push(16'h0042, 16'h7788);
    repeat (48) tick();
    frame(16'h0042, 16'h7788);
    status_check("rep_suppressed", 16'h0401);
    reg_wr(REG_CLR, 16'h0400);
    repeat (160) tick();
    frame(16'h0042, 16'h7788);
    sb_push(16'h0042, 16'h7788);
    status_check("rep_expired", 16'h0002);
    pop_check("rep_pop0");
    pop_check("rep_pop1");

    // Overflow at depth 8
    reg_wr(REG_CTRL, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      cmd = 8'h10 + 8'(i);
      frame(16'h0100 + 16'(i), {~cmd, cmd});
      if (i < 8) sb_push(16'h0100 + 16'(i), {~cmd, cmd});
    end
    status_check("ovf_status", 16'h0188);

    // Push and pop in the same cycle while full
    dv = 1'b1; da = 16'h0109; dd = 16'hE619;
    tick();
    dv = 1'b0;
    cs = 1'b1; rd = 1'b1; addr = REG_HEAD;
    tick();
    cs = 1'b0; rd = 1'b0;
    e = sb.pop_front();
    check("full_pushpop_head", rddata, e);
    sb_push(16'h0109, 16'hE619);
    status_check("full_pushpop_status", 16'h0188);
    reg_wr(REG_CLR, 16'h0100);
    status_check("ovf_cleared", 16'h0088);
    for (int i = 0; i < 9; i++) pop_check($sformatf("ovf_drain%0d", i));
    status_check("ovf_empty", 16'h0000);

    // Flush, including flush on the push cycle
    frame(16'h0001, 16'hFE01);
    frame(16'h0002, 16'hFD02);
    reg_wr(REG_FLUSH, 16'h0000);
    status_check("flush_status", 16'h0000);
    dv = 1'b1; da = 16'h0003; dd = 16'hFC03;
    tick();
    dv = 1'b0;
    cs = 1'b1; wr = 1'b1; addr = REG_FLUSH;
    tick();
    cs = 1'b0; wr = 1'b0;
    status_check("flush_wins", 16'h0000);

    // Strobe during CHECK is dropped as overflow
    dv = 1'b1; da = 16'h0004; dd = 16'hFB04;
    tick();
    da = 16'h0005; dd = 16'hFA05;
    tick();
    dv = 1'b0;
    tick();
    sb_push(16'h0004, 16'hFB04);
    status_check("busy_drop_status", 16'h0101);
    pop_check("busy_drop_head");
    reg_wr(REG_CLR, 16'h0700);

    // W1C in the same cycle as a set: the set wins
    dv = 1'b1; da = 16'h0006; dd = 16'h0006;
    tick();
    dv = 1'b0;
    cs = 1'b1; wr = 1'b1; addr = REG_CLR; wrdata = 16'h0200;
    tick();
    cs = 1'b0; wr = 1'b0;
    status_check("w1c_set_wins", 16'h0200);

    // Mid-queue reset
    reg_wr(REG_CTRL, 16'h0001);
    frame(16'h0007, 16'hF807);
    frame(16'h0008, 16'hF708);
    reg_wr(REG_FILT, 16'h1234);
    reg_rd(REG_STATUS, d);
    check("pre_reset_status", d, 16'h0A02);
    check("pre_reset_irq", {15'd0, irq}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_irq", {15'd0, irq}, 16'h0000);
    check("mid_reset_rddata", rddata, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    sb.delete();
    status_check("post_reset_status", 16'h0000);
    reg_rd(REG_CTRL, d);
    check("post_reset_ctrl", d, 16'h0000);
    reg_rd(REG_FILT, d);
    check("post_reset_filter", d, 16'h0000);
    pop_check("post_reset_head");
    check("post_reset_irq", {15'd0, irq}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
